// File: rtl/uart_rx_block_if.sv
// rtl/uart_rx_block_if.sv - serial input and byte/block/error outputs of uart_rx_block
interface uart_rx_block_if;
   logic         rx_in;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic [127:0] block_out;
   logic         block_valid;
   logic         frame_err;

   modport slave (
      input  rx_in,
      output byte_out, byte_valid, block_out, block_valid, frame_err
   );

   modport master (
      output rx_in,
      input  byte_out, byte_valid, block_out, block_valid, frame_err
   );
endinterface

// File: rtl/uart_rx_block.sv
// rtl/uart_rx_block.sv - UART receiver packing 16 bytes per 128-bit block
// Optional even-parity frames (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx_block #(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_block_if.slave bus
);
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW       = $clog2(TO_LIMIT);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_M1   = TW'(TO_LIMIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t         r_state, w_next;
   logic           r_sync1, r_rxs, r_rxs_d;
   logic [CW-1:0]  r_clk_cnt;
   logic [2:0]     r_bit_cnt;
   logic [7:0]     r_shift;
   logic [127:0]   r_buf;
   logic [3:0]     r_byte_count;
   logic [TW-1:0]  r_idle_cnt;
   logic [7:0]     r_byte_out;
   logic           r_byte_valid;
   logic [127:0]   r_block_out;
   logic           r_block_valid;
   logic           r_frame_err;
`ifdef UART_RX_PARITY_EN
   logic           r_par_bad;
`endif

   logic w_tick, w_shift, w_good, w_bad, w_timeout, w_fall;

   assign w_tick = (r_state == S_START) ? (r_clk_cnt == HALF_M1) : (r_clk_cnt == FULL_M1);
   assign w_fall = !r_rxs && r_rxs_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_fall) w_next = S_START;
         S_START:  if (w_tick) w_next = r_rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
         S_DATA:   if (w_tick && r_bit_cnt == 3'd7) w_next = S_PARITY;
         S_PARITY: if (w_tick) w_next = S_STOP;
`else
         S_DATA:   if (w_tick && r_bit_cnt == 3'd7) w_next = S_STOP;
`endif
         S_STOP:   if (w_tick) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_shift   = (r_state == S_DATA) && w_tick;
`ifdef UART_RX_PARITY_EN
      w_good    = (r_state == S_STOP) && w_tick && r_rxs && !r_par_bad;
`else
      w_good    = (r_state == S_STOP) && w_tick && r_rxs;
`endif
      w_bad     = (r_state == S_STOP) && w_tick && !w_good;
      w_timeout = (r_state == S_IDLE) && (r_byte_count != 4'd0) && (r_idle_cnt == TO_M1);
   end

   // Synchroniser idles high so reset never looks like a start edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_rxs   <= 1'b1;
         r_rxs_d <= 1'b1;
      end else begin
         r_sync1 <= bus.rx_in;
         r_rxs   <= r_sync1;
         r_rxs_d <= r_rxs;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_cnt <= '0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         r_clk_cnt <= (r_state == S_IDLE || w_tick) ? '0 : r_clk_cnt + 1'b1;
         if (r_state == S_IDLE) r_bit_cnt <= 3'd0;
         else if (w_shift)      r_bit_cnt <= r_bit_cnt + 3'd1;
         if (w_shift)           r_shift   <= {r_rxs, r_shift[7:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                r_par_bad <= 1'b0;
      else if (r_state == S_PARITY && w_tick)   r_par_bad <= (^r_shift) ^ r_rxs;
   end
`endif

   // Timeout only runs while a partial block is pending
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= '0;
      end else if (r_state != S_IDLE || r_byte_count == 4'd0 || w_timeout) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf         <= '0;
         r_byte_count  <= 4'd0;
         r_byte_out    <= 8'd0;
         r_byte_valid  <= 1'b0;
         r_block_out   <= '0;
         r_block_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_byte_valid  <= w_good;
         r_frame_err   <= w_bad;
         r_block_valid <= w_good && (r_byte_count == 4'd15);
         if (w_timeout) begin
            r_byte_count <= 4'd0;
            r_buf        <= '0;
         end else if (w_good) begin
            r_byte_out                      <= r_shift;
            r_buf[{~r_byte_count, 3'b000} +: 8] <= r_shift;
            r_byte_count                    <= r_byte_count + 4'd1;
            if (r_byte_count == 4'd15) r_block_out <= {r_buf[127:8], r_shift};
         end
      end
   end

   assign bus.byte_out    = r_byte_out;
   assign bus.byte_valid  = r_byte_valid;
   assign bus.block_out   = r_block_out;
   assign bus.block_valid = r_block_valid;
   assign bus.frame_err   = r_frame_err;
endmodule

// File: tb/tb_uart_rx_block.sv
// tb/tb_uart_rx_block.sv - directed bench for uart_rx_block at 4 clocks per bit
module tb_uart_rx_block;
   localparam int CPB = 4;

   logic clk;
   logic reset;
   uart_rx_block_if bus ();

   uart_rx_block #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int n_byte = 0, n_block = 0, n_ferr = 0, n_coinc = 0, n_blk_alone = 0;
   logic [7:0]   last_byte;
   logic [127:0] last_block;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.byte_valid) begin
            n_byte++;
            last_byte = bus.byte_out;
         end
         if (bus.block_valid) begin
            n_block++;
            last_block = bus.block_out;
            if (!bus.byte_valid) n_blk_alone++;
         end
         if (bus.frame_err) n_ferr++;
         if (bus.frame_err && bus.byte_valid) n_coinc++;
      end
   end

   task automatic drive_bit(input logic b);
      bus.rx_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int cycles);
      bus.rx_in = 1'b1;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`else
      if (par === 1'bx) bus.rx_in = 1'b1;
`endif
      drive_bit(stop);
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_frame(d, ^d, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.rx_in = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte_out got=%h want=00", bus.byte_out); end
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL reset_byte_valid got=%b want=0", bus.byte_valid); end
      total++; if (bus.block_out !== 128'h0) begin bad++; $display("FAIL reset_block_out got=%h want=0", bus.block_out); end
      total++; if (bus.block_valid !== 1'b0) begin bad++; $display("FAIL reset_block_valid got=%b want=0", bus.block_valid); end
      total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", bus.frame_err); end
   endtask

   task automatic test_single_byte();
      int b0, k0, f0;
      do_reset();
      b0 = n_byte; k0 = n_block; f0 = n_ferr;
      send_byte(8'hA5);
      idle(8);
      total++; if (n_byte - b0 != 1) begin bad++; $display("FAIL single_count got=%0d want=1", n_byte - b0); end
      total++; if (bus.byte_out !== 8'hA5) begin bad++; $display("FAIL single_byte got=%h want=a5", bus.byte_out); end
      total++; if (n_block - k0 != 0) begin bad++; $display("FAIL single_block got=%0d want=0", n_block - k0); end
      total++; if (n_ferr - f0 != 0) begin bad++; $display("FAIL single_ferr got=%0d want=0", n_ferr - f0); end
   endtask

   task automatic test_back_to_back();
      int b0, k0, a0;
      do_reset();
      b0 = n_byte; k0 = n_block; a0 = n_blk_alone;
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      idle(8);
      total++; if (n_byte - b0 != 16) begin bad++; $display("FAIL b2b_bytes got=%0d want=16", n_byte - b0); end
      total++; if (n_block - k0 != 1) begin bad++; $display("FAIL b2b_blocks got=%0d want=1", n_block - k0); end
      total++; if (last_block !== 128'h000102030405060708090A0B0C0D0E0F) begin bad++; $display("FAIL b2b_block got=%h want=000102030405060708090a0b0c0d0e0f", last_block); end
      total++; if (n_blk_alone - a0 != 0) begin bad++; $display("FAIL b2b_block_coinc got=%0d want=0", n_blk_alone - a0); end
   endtask

   task automatic test_framing_error();
      int b0, k0, f0, c0;
      do_reset();
      b0 = n_byte; f0 = n_ferr; c0 = n_coinc;
      send_frame(8'h3C, ^8'h3C, 1'b0);
      idle(8);
      total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", n_ferr - f0); end
      total++; if (n_byte - b0 != 0) begin bad++; $display("FAIL ferr_bytes got=%0d want=0", n_byte - b0); end
      total++; if (bus.byte_out !== 8'h00) begin bad++; $display("FAIL ferr_byte_out got=%h want=00", bus.byte_out); end
      k0 = n_block;
      for (int i = 0; i < 15; i++) send_byte(8'(8'h20 + i));
      idle(4);
      total++; if (n_block - k0 != 0) begin bad++; $display("FAIL ferr_early_block got=%0d want=0", n_block - k0); end
      send_byte(8'h2F);
      idle(8);
      total++; if (n_block - k0 != 1) begin bad++; $display("FAIL ferr_block_count got=%0d want=1", n_block - k0); end
      total++; if (last_block !== 128'h202122232425262728292A2B2C2D2E2F) begin bad++; $display("FAIL ferr_block got=%h want=202122232425262728292a2b2c2d2e2f", last_block); end
      total++; if (n_coinc - c0 != 0) begin bad++; $display("FAIL ferr_coinc got=%0d want=0", n_coinc - c0); end
   endtask

   task automatic test_glitch();
      int b0, k0, f0;
      do_reset();
      b0 = n_byte; k0 = n_block; f0 = n_ferr;
      @(negedge clk);
      bus.rx_in = 1'b0;
      @(negedge clk);
      bus.rx_in = 1'b1;
      idle(60);
      total++; if ((n_byte - b0) + (n_block - k0) + (n_ferr - f0) != 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", (n_byte - b0) + (n_block - k0) + (n_ferr - f0)); end
   endtask

   task automatic test_timeout();
      int k0;
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i));
      idle(21 * CPB);
      k0 = n_block;
      for (int i = 0; i < 11; i++) send_byte(8'(8'h10 + i));
      idle(4);
      total++; if (n_block - k0 != 0) begin bad++; $display("FAIL timeout_stale_block got=%0d want=0", n_block - k0); end
      for (int i = 11; i < 16; i++) send_byte(8'(8'h10 + i));
      idle(8);
      total++; if (n_block - k0 != 1) begin bad++; $display("FAIL timeout_blocks got=%0d want=1", n_block - k0); end
      total++; if (last_block !== 128'h101112131415161718191A1B1C1D1E1F) begin bad++; $display("FAIL timeout_block got=%h want=101112131415161718191a1b1c1d1e1f", last_block); end
   endtask

   task automatic test_reset_mid_frame();
      int b0;
      do_reset();
      send_byte(8'h55);
      idle(8);
      total++; if (bus.byte_out !== 8'h55) begin bad++; $display("FAIL midrst_pre got=%h want=55", bus.byte_out); end
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      bus.rx_in = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (bus.byte_out !== 8'h00) begin bad++; $display("FAIL midrst_byte_out got=%h want=00", bus.byte_out); end
      total++; if ({bus.byte_valid, bus.block_valid, bus.frame_err} !== 3'b000) begin bad++; $display("FAIL midrst_pulses got=%b want=000", {bus.byte_valid, bus.block_valid, bus.frame_err}); end
      @(negedge clk);
      bus.rx_in = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle(8);
      b0 = n_byte;
      send_byte(8'h81);
      idle(8);
      total++; if (n_byte - b0 != 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", n_byte - b0); end
      total++; if (bus.byte_out !== 8'h81) begin bad++; $display("FAIL midrst_byte got=%h want=81", bus.byte_out); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int b0, f0;
      do_reset();
      b0 = n_byte; f0 = n_ferr;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(8);
      total++; if (n_byte - b0 != 1) begin bad++; $display("FAIL par_good_count got=%0d want=1", n_byte - b0); end
      total++; if (bus.byte_out !== 8'h07) begin bad++; $display("FAIL par_good_byte got=%h want=07", bus.byte_out); end
      b0 = n_byte;
      send_frame(8'h07, 1'b0, 1'b1);
      idle(8);
      total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL par_bad_ferr got=%0d want=1", n_ferr - f0); end
      total++; if (n_byte - b0 != 0) begin bad++; $display("FAIL par_bad_bytes got=%0d want=0", n_byte - b0); end
   endtask
`endif

   initial begin
      bus.rx_in = 1'b1;
      reset = 1'b1;
      #10;
      reset = 1'b0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_framing_error();
      test_glitch();
      test_timeout();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
